// File: rtl/mmc1_serial_loader_pkg.sv
// Shared constants and types for the MMC1 serial loader and register stage.
package mmc1_pkg;

  localparam int MMC1_SHIFT_W = 5;

  // Register select decoded from A14:A13 of the fifth write.
  localparam logic [1:0] REG_CONTROL = 2'd0;
  localparam logic [1:0] REG_CHR0    = 2'd1;
  localparam logic [1:0] REG_CHR1    = 2'd2;
  localparam logic [1:0] REG_PRG     = 2'd3;

  // Bits the register stage ORs into control when reset_cmd fires.
  localparam logic [MMC1_SHIFT_W-1:0] CTRL_RESET_MASK = 5'b01100;

  // Loader state is the count of bits currently held.
  typedef enum logic [2:0] {
    LD_IDLE = 3'd0,
    LD_B1   = 3'd1,
    LD_B2   = 3'd2,
    LD_B3   = 3'd3,
    LD_B4   = 3'd4
  } ld_state_e;

  typedef struct packed {
    logic [1:0]              sel;
    logic [MMC1_SHIFT_W-1:0] data;
  } reg_load_t;

  // LSB-first serial shift: new bit enters at the top.
  function automatic logic [MMC1_SHIFT_W-1:0] shift_in(
    input logic [MMC1_SHIFT_W-1:0] sh,
    input logic                    d0
  );
    return {d0, sh[MMC1_SHIFT_W-1:1]};
  endfunction

endpackage

// File: rtl/mmc1_serial_loader_if.sv
// CPU-side bus and register-stage strobes of the MMC1 serial loader.
interface mmc1_serial_loader_if;
  import mmc1_pkg::*;

  logic                    romsel;
  logic                    cpu_rw_in;
  logic [1:0]              cpu_addr_in;
  logic [7:0]              cpu_data_in;
  logic                    reg_wr;
  logic [1:0]              reg_sel;
  logic [MMC1_SHIFT_W-1:0] reg_data;
  logic                    reset_cmd;
  logic                    load_busy;
  logic                    timeout_abort;

  modport slave (
    input  romsel, cpu_rw_in, cpu_addr_in, cpu_data_in,
    output reg_wr, reg_sel, reg_data, reset_cmd, load_busy, timeout_abort
  );

  modport master (
    output romsel, cpu_rw_in, cpu_addr_in, cpu_data_in,
    input  reg_wr, reg_sel, reg_data, reset_cmd, load_busy, timeout_abort
  );

endinterface

// File: rtl/mmc1_serial_loader_write_filter.sv
// Write-cycle detect with back-to-back suppression: only the first of a run
// of adjacent write cycles is accepted (RMW dummy writes are dropped).
module mmc1_write_filter
  import mmc1_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic romsel_i,
  input  logic cpu_rw_i,
  output logic accepted_o
);

  logic wr_cyc;
  logic prev_wr_q;

  assign wr_cyc = !romsel_i && !cpu_rw_i;

  // Remember whether the previous M2 cycle was a mapper write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_wr_q <= 1'b0;
    else        prev_wr_q <= wr_cyc;
  end

  assign accepted_o = wr_cyc && !prev_wr_q;

endmodule

// File: rtl/mmc1_serial_loader.sv
// MMC1 serial loader: filters CPU writes and assembles 5-bit register loads.
// Optional inactivity abort of partial loads: define SERIAL_TIMEOUT_EN.
module mmc1_serial_loader
  import mmc1_pkg::*;
#(
  parameter int SHIFT_WIDTH    = MMC1_SHIFT_W,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 m2,
  input  logic                 rst_n,
  mmc1_serial_loader_if.slave  bus
);

  // State reached after the last-but-one bit; the next bit completes a load.
  localparam ld_state_e LAST_ST = ld_state_e'(3'(SHIFT_WIDTH - 1));

  logic [1:0]              rst_pipe_q;
  logic                    rst_n_s;
  logic                    accepted;
  logic                    d7, d0;
  logic                    data_unused;
  ld_state_e               st_q, st_d;
  logic [MMC1_SHIFT_W-1:0] shift_q, shift_d;
  reg_load_t               load_q, load_d;
  logic                    reg_wr_q, reg_wr_d;
  logic                    reset_cmd_q, reset_cmd_d;
  logic                    busy_q, busy_d;

  // Async assert, release synchronised to m2 over two flops.
  always_ff @(posedge m2 or negedge rst_n) begin
    if (!rst_n) rst_pipe_q <= 2'b00;
    else        rst_pipe_q <= {rst_pipe_q[0], 1'b1};
  end
  assign rst_n_s = rst_pipe_q[1];

  mmc1_write_filter u_filt (
    .clk        (m2),
    .rst_n      (rst_n_s),
    .romsel_i   (bus.romsel),
    .cpu_rw_i   (bus.cpu_rw_in),
    .accepted_o (accepted)
  );

  assign d7          = bus.cpu_data_in[7];
  assign d0          = bus.cpu_data_in[0];
  assign data_unused = ^bus.cpu_data_in[6:1];

`ifdef SERIAL_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] tmo_q, tmo_d;
  logic        expire;
  logic        abort_q, abort_d;

  // Expiry only matters mid-load, and an accepted write that cycle wins.
  assign expire = (st_q != LD_IDLE) && (tmo_q == TMO_LAST) && !accepted;

  // Idle counter: runs only while bits are held without a new write.
  always_comb begin
    tmo_d = tmo_q + 16'd1;
    if (accepted || st_q == LD_IDLE || expire) tmo_d = 16'd0;
  end

  // Timeout counter and abort strobe registers.
  always_ff @(posedge m2 or negedge rst_n_s) begin
    if (!rst_n_s) begin
      tmo_q   <= 16'd0;
      abort_q <= 1'b0;
    end else begin
      tmo_q   <= tmo_d;
      abort_q <= abort_d;
    end
  end

  assign bus.timeout_abort = abort_q;
`else
  int tmo_unused;
  assign tmo_unused        = TIMEOUT_CYCLES;
  assign bus.timeout_abort = 1'b0;
`endif

  // Next state: D7 reset beats everything, the last bit emits a load.
  always_comb begin
    st_d        = st_q;
    shift_d     = shift_q;
    load_d      = load_q;
    reg_wr_d    = 1'b0;
    reset_cmd_d = 1'b0;
`ifdef SERIAL_TIMEOUT_EN
    abort_d     = 1'b0;
`endif
    if (accepted) begin
      if (d7) begin
        st_d        = LD_IDLE;
        shift_d     = '0;
        reset_cmd_d = 1'b1;
      end else if (st_q == LAST_ST) begin
        load_d.sel  = bus.cpu_addr_in;
        load_d.data = shift_in(shift_q, d0);
        reg_wr_d    = 1'b1;
        st_d        = LD_IDLE;
        shift_d     = '0;
      end else begin
        shift_d = shift_in(shift_q, d0);
        st_d    = ld_state_e'(st_q + 3'd1);
      end
    end
`ifdef SERIAL_TIMEOUT_EN
    else if (expire) begin
      st_d    = LD_IDLE;
      shift_d = '0;
      abort_d = 1'b1;
    end
`endif
    busy_d = (st_d != LD_IDLE);
  end

  // Loader state and registered outputs.
  always_ff @(posedge m2 or negedge rst_n_s) begin
    if (!rst_n_s) begin
      st_q        <= LD_IDLE;
      shift_q     <= '0;
      load_q      <= '0;
      reg_wr_q    <= 1'b0;
      reset_cmd_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      st_q        <= st_d;
      shift_q     <= shift_d;
      load_q      <= load_d;
      reg_wr_q    <= reg_wr_d;
      reset_cmd_q <= reset_cmd_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.reg_wr    = reg_wr_q;
  assign bus.reg_sel   = load_q.sel;
  assign bus.reg_data  = load_q.data;
  assign bus.reset_cmd = reset_cmd_q;
  assign bus.load_busy = busy_q;

endmodule

// File: tb/tb_mmc1_serial_loader.sv
// Scoreboard bench for mmc1_serial_loader: expected strobes are queued as
// stimulus is driven and matched when the DUT raises a strobe.
module tb_mmc1_serial_loader;
  import mmc1_pkg::*;

  localparam logic [2:0] EV_WR  = 3'b001;
  localparam logic [2:0] EV_RST = 3'b010;
  localparam logic [2:0] EV_ABT = 3'b100;

  typedef struct {
    logic [2:0] kind;
    logic [1:0] sel;
    logic [4:0] data;
  } ev_t;

  logic m2 = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_bad = 0;
  ev_t  ev_q[$];

  mmc1_serial_loader_if bus();

  mmc1_serial_loader #(.SHIFT_WIDTH(MMC1_SHIFT_W), .TIMEOUT_CYCLES(16)) dut (
    .m2    (m2),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 m2 = ~m2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [2:0] k, input logic [1:0] s, input logic [4:0] d);
    ev_t e;
    e.kind = k;
    e.sel  = s;
    e.data = d;
    ev_q.push_back(e);
  endtask

  task automatic drive(input logic rs, input logic rw, input logic [1:0] a, input logic [7:0] d);
    @(negedge m2);
    bus.romsel      = rs;
    bus.cpu_rw_in   = rw;
    bus.cpu_addr_in = a;
    bus.cpu_data_in = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b1, 1'b1, 2'd0, 8'h00);
  endtask

  // Isolated write followed by one idle cycle.
  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    drive(1'b0, 1'b0, a, d);
    idle(1);
  endtask

  // Strobe monitor: every strobe must match the oldest queued expectation.
  always @(negedge m2) begin
    logic [2:0] got;
    ev_t        e;
    got = {bus.timeout_abort, bus.reset_cmd, bus.reg_wr};
    if (got != 3'b000) begin
      if (ev_q.size() == 0) chk("unexp_strobe", got, 3'b000);
      else begin
        e = ev_q.pop_front();
        chk("strobe", got, e.kind);
        if (e.kind == EV_WR) begin
          chk("reg_sel", bus.reg_sel, e.sel);
          chk("reg_data", bus.reg_data, e.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n           = 1'b1;
    bus.romsel      = 1'b1;
    bus.cpu_rw_in   = 1'b1;
    bus.cpu_addr_in = 2'd0;
    bus.cpu_data_in = 8'h00;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge m2);
    chk("rst_reg_wr", bus.reg_wr, 0);
    chk("rst_reg_sel", bus.reg_sel, 0);
    chk("rst_reg_data", bus.reg_data, 0);
    chk("rst_reset_cmd", bus.reset_cmd, 0);
    chk("rst_busy", bus.load_busy, 0);
    chk("rst_abort", bus.timeout_abort, 0);
    rst_n = 1'b1;
    idle(4);

    // Five writes to $E000, D0=1,0,1,1,0 with ignored read/non-ROM cycles mixed in.
    wr(2'd3, 8'h01);
    drive(1'b0, 1'b1, 2'd3, 8'h80);
    drive(1'b1, 1'b0, 2'd3, 8'h80);
    idle(1);
    wr(2'd3, 8'h00);
    chk("t1_busy_mid", bus.load_busy, 1);
    wr(2'd3, 8'h01);
    wr(2'd3, 8'h01);
    push(EV_WR, REG_PRG, 5'b01101);
    wr(2'd3, 8'h00);
    chk("t1_busy_end", bus.load_busy, 0);
    idle(2);
    chk("t1_hold_sel", bus.reg_sel, REG_PRG);
    chk("t1_hold_data", bus.reg_data, 5'b01101);

    // Three bits then D7 reset; outputs hold; then $8000 with all ones.
    repeat (3) wr(2'd2, 8'h01);
    push(EV_RST, 2'd0, 5'd0);
    wr(2'd2, 8'h80);
    chk("t2_busy_rst", bus.load_busy, 0);
    chk("t2_hold_sel", bus.reg_sel, REG_PRG);
    chk("t2_hold_data", bus.reg_data, 5'b01101);
    repeat (4) wr(2'd0, 8'h01);
    push(EV_WR, REG_CONTROL, 5'b11111);
    wr(2'd0, 8'h01);
    chk("t2_busy_end", bus.load_busy, 0);

    // Four bits, then INC-style adjacent pair to $FFFF: only 0x00 counts.
    repeat (4) wr(2'd2, 8'h01);
    push(EV_WR, REG_PRG, 5'b01111);
    drive(1'b0, 1'b0, 2'd3, 8'h00);
    drive(1'b0, 1'b0, 2'd3, 8'h01);
    idle(1);
    chk("t3_busy_pair", bus.load_busy, 0);
    repeat (4) wr(2'd0, 8'h00);
    push(EV_WR, REG_CONTROL, 5'b00000);
    wr(2'd0, 8'h00);

    // Adjacent 0x80 pair yields exactly one reset_cmd.
    wr(2'd0, 8'h01);
    push(EV_RST, 2'd0, 5'd0);
    drive(1'b0, 1'b0, 2'd0, 8'h80);
    drive(1'b0, 1'b0, 2'd0, 8'h80);
    idle(1);
    chk("t4_busy", bus.load_busy, 0);

    // rst_n mid-load, then a clean load to $A000 with D0=0,1,1,0,1.
    wr(2'd1, 8'h01);
    wr(2'd1, 8'h01);
    rst_n = 1'b0;
    #1;
    chk("t5_busy_rst", bus.load_busy, 0);
    chk("t5_sel_rst", bus.reg_sel, 0);
    chk("t5_data_rst", bus.reg_data, 0);
    idle(2);
    rst_n = 1'b1;
    idle(4);
    wr(2'd1, 8'h00);
    wr(2'd1, 8'h01);
    wr(2'd1, 8'h01);
    wr(2'd1, 8'h00);
    push(EV_WR, REG_CHR0, 5'b10110);
    wr(2'd1, 8'h01);
    chk("t5_busy_end", bus.load_busy, 0);

    // Two bits then a long idle stretch.
    wr(2'd0, 8'h01);
    wr(2'd0, 8'h01);
`ifdef SERIAL_TIMEOUT_EN
    push(EV_ABT, 2'd0, 5'd0);
    idle(18);
    chk("t6_busy_abort", bus.load_busy, 0);
`else
    idle(18);
    chk("t6_busy_persist", bus.load_busy, 1);
`endif
    push(EV_RST, 2'd0, 5'd0);
    wr(2'd0, 8'h80);
    chk("t6_busy_end", bus.load_busy, 0);

    idle(3);
    chk("sb_empty", ev_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
